truth_table_extractor: RTL
==========================

// Module: truth_table_extractor
// PURPOSE
//  Inverse of our SOP evaluators: sweeps every input combination of an N-var
//  combinational function, samples its response and builds the truth table.
//  It then streams the minterm indices out over a valid/ready port for the
//  downstream minimizer.
//  Sits between a function-under-probe (any SOP block) and the minimization flow.
// PARAMETERS
//  N_VARS    4  number of function inputs; truth table has 2**N_VARS entries
//  EVAL_LAT  1  cycles from probe_vec driven to resp_bit valid (>=1)
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          begin extraction; sampled only in IDLE
//  busy       out  1          high from accept of start until done pulse
//  done       out  1          one-cycle pulse, extraction and emission complete
//  probe_vec  out  N_VARS     input combination driven to function
//  probe_vld  out  1          probe_vec is a live probe this cycle
//  resp_bit   in   1          function output for the probe of EVAL_LAT cycles ago
//  tt         out  2**N_VARS  captured truth table, bit i = f(i)
//  mt_count   out  N_VARS+1   number of set bits in tt
//  mt_valid   out  1          mt_index valid
//  mt_ready   in   1          consumer accepts mt_index
//  mt_index   out  N_VARS     minterm index, ascending order
//  mt_last    out  1          with mt_valid: final minterm
// BEHAVIOUR
//  Reset: every output 0, tt=0, mt_count=0, state IDLE.
//  FSM IDLE -> SWEEP -> EMIT -> FIN -> IDLE.
//  IDLE: start=1 -> clear tt/mt_count, busy=1, go SWEEP. start ignored elsewhere.
//  SWEEP: probe_vld=1 for 2**N_VARS consecutive cycles, probe_vec=0,1,...,max.
//   Probe index is delayed EVAL_LAT cycles in a tag pipe; when the tag is valid,
//   tt[tag]<=resp_bit and mt_count increments if 1. The sweep ends when the last
//   tag retires, 2**N_VARS+EVAL_LAT cycles after entry. probe_vec holds 0 when
//   probe_vld=0.
//  EMIT: scan pointer p starts at 0 and advances 1 index/cycle over clear bits.
//   At a set bit: mt_valid=1, mt_index=p, mt_last=(no set bit above p).
//   mt_index and mt_last hold stable until mt_valid&mt_ready; then p advances.
//   After the transfer with mt_last, or immediately if mt_count==0, go FIN.
//  FIN: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
//  tt and mt_count hold until the next accepted start.
//  mt_valid never deasserts without a handshake; no bubbles are required.
//  rst mid-operation: abandon, all outputs to reset values next edge.
//  Widths: mt_count N_VARS+1 bits so the all-ones table (2**N_VARS) fits.
// STRUCTURE
//  Package tte_pkg: state enum {IDLE,SWEEP,EMIT,FIN}, localparam
//   N_MT = 2**N_VARS, helper function f_any_above(tt,p).
//  One sub-module, tte_emit: scan pointer, valid/ready hold, mt_last logic.
//  Top: FSM, probe counter, EVAL_LAT tag pipe, tt/mt_count registers.
// TESTING
//  N=4,EVAL_LAT=1, resp=1 for {0,2,8,10}, mt_ready=1 -> tt=16'h0505,
//   mt_count=4, mt_index 0,2,8,10, mt_last only on 10, done once.
//  resp const 0 -> tt=0, mt_count=0, mt_valid never high,
//   done 2**4+1+1 cycles after SWEEP entry.
//  resp const 1, mt_ready=1 -> 16 minterms 0..15, mt_count=5'd16,
//   mt_last on 15.
//  Backpressure: mt_ready=0 for 5 cycles while mt_valid=1 -> mt_index and
//   mt_last stable, no index lost or repeated.
//  rst asserted mid-SWEEP, start held high -> next cycle all outputs 0 and
//   busy=0; start pulsed during busy is ignored.
//  EVAL_LAT=3 with a 3-stage delayed model of resp={5,6} -> tt=16'h0060,
//   minterms 5,6.

Source files
------------

// File: rtl/tte_pkg.sv
// Shared types and helpers for the truth-table extractor.
package tte_pkg;

   localparam int TTE_N_VARS   = 4;
   localparam int TTE_N_MT     = 2**TTE_N_VARS;
   // Upper bound for the scan helper; covers functions of up to 8 inputs.
   localparam int TTE_MAX_VARS = 8;
   localparam int TTE_MAX_MT   = 2**TTE_MAX_VARS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      EMIT  = 2'd2,
      FIN   = 2'd3
   } tte_state_e;

   // True when any truth-table bit strictly above position p is set.
   function automatic logic f_any_above(input logic [TTE_MAX_MT-1:0]   tt,
                                        input logic [TTE_MAX_VARS-1:0] p);
      logic [TTE_MAX_MT-1:0] above;
      above = (tt >> p) >> 1;
      return |above;
   endfunction

endpackage

// File: rtl/tte_emit.sv
// Minterm emitter: walks the captured truth table in ascending order and
// presents each set index on a valid/ready port, holding it until accepted.
module tte_emit
   import tte_pkg::*;
#(
   parameter int N_VARS = TTE_N_VARS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [2**N_VARS-1:0]   tt,
   input  logic                   mt_ready,
   output logic                   mt_valid,
   output logic [N_VARS-1:0]      mt_index,
   output logic                   mt_last,
   output logic                   xfer_last
);

   localparam int N_MT = 2**N_VARS;

   logic [N_VARS-1:0]       ptr;
   logic [TTE_MAX_MT-1:0]   tt_ext;
   logic [TTE_MAX_VARS-1:0] ptr_ext;
   logic                    hit;

   // Widen table and pointer to the helper's fixed argument widths.
   always_comb begin
      tt_ext                 = '0;
      tt_ext[N_MT-1:0]       = tt;
      ptr_ext                = '0;
      ptr_ext[N_VARS-1:0]    = ptr;
   end

   // Pointer only moves on a clear bit or an accepted minterm, so index/last hold under backpressure.
   assign hit       = en & tt[ptr];
   assign mt_valid  = hit;
   assign mt_index  = hit ? ptr : '0;
   assign mt_last   = hit & ~f_any_above(tt_ext, ptr_ext);
   assign xfer_last = mt_last & mt_ready;

   // Scan pointer: parked at 0 outside EMIT, advances one index per cycle otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (!en) begin
         ptr <= '0;
      end else if (!hit || mt_ready) begin
         ptr <= ptr + N_VARS'(1);
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/truth_table_extractor.sv
// Truth-table extractor: sweeps all input combinations of a probed function,
// captures its response into tt and streams the minterm indices out.
module truth_table_extractor
   import tte_pkg::*;
#(
   parameter int N_VARS   = TTE_N_VARS,
   parameter int EVAL_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [N_VARS-1:0]      probe_vec,
   output logic                   probe_vld,
   input  logic                   resp_bit,
   output logic [2**N_VARS-1:0]   tt,
   output logic [N_VARS:0]        mt_count,
   output logic                   mt_valid,
   input  logic                   mt_ready,
   output logic [N_VARS-1:0]      mt_index,
   output logic                   mt_last
);

   localparam int N_MT = 2**N_VARS;

   tte_state_e          state;
   tte_state_e          state_nxt;
   logic [N_VARS:0]     probe_cnt;
   logic [N_VARS-1:0]   tag_idx [EVAL_LAT];
   logic                tag_vld [EVAL_LAT];
   logic                tag_ret_vld;
   logic [N_VARS-1:0]   tag_ret_idx;
   logic                sweep_last;
   logic                start_acc;
   logic                emit_en;
   logic                emit_last;

   assign start_acc   = (state == IDLE) && start;
   assign probe_vld   = (state == SWEEP) && (probe_cnt < (N_VARS+1)'(N_MT));
   assign probe_vec   = probe_vld ? probe_cnt[N_VARS-1:0] : '0;
   assign tag_ret_vld = tag_vld[EVAL_LAT-1];
   assign tag_ret_idx = tag_idx[EVAL_LAT-1];
   assign sweep_last  = tag_ret_vld && (tag_ret_idx == N_VARS'(N_MT-1));
   assign emit_en     = (state == EMIT);
   assign busy        = (state == SWEEP) || (state == EMIT);
   assign done        = (state == FIN);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: sweep until the last tag retires, emit until the final minterm is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SWEEP;
            else       state_nxt = IDLE;
         end
         SWEEP: begin
            if (sweep_last) state_nxt = EMIT;
            else            state_nxt = SWEEP;
         end
         EMIT: begin
            if ((mt_count == '0) || emit_last) state_nxt = FIN;
            else                               state_nxt = EMIT;
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Probe counter: issues 0..N_MT-1, then stops while the tag pipe drains.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         probe_cnt <= '0;
      end else if (probe_vld) begin
         probe_cnt <= probe_cnt + (N_VARS+1)'(1);
      end else begin
         probe_cnt <= probe_cnt;
      end
   end

   // Tag pipe: pairs each probe index with the response arriving EVAL_LAT cycles later.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         for (int i = 0; i < EVAL_LAT; i++) begin
            tag_vld[i] <= 1'b0;
            tag_idx[i] <= '0;
         end
      end else begin
         tag_vld[0] <= probe_vld;
         tag_idx[0] <= probe_vec;
         for (int i = 1; i < EVAL_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   // Truth table and minterm count: cleared on accepted start, held after the sweep.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         tt       <= '0;
         mt_count <= '0;
      end else if ((state == SWEEP) && tag_ret_vld) begin
         tt[tag_ret_idx] <= resp_bit;
         if (resp_bit) mt_count <= mt_count + (N_VARS+1)'(1);
         else          mt_count <= mt_count;
      end else begin
         tt       <= tt;
         mt_count <= mt_count;
      end
   end

   tte_emit #(
      .N_VARS (N_VARS)
   ) u_emit (
      .clk       (clk),
      .rst       (rst),
      .en        (emit_en),
      .tt        (tt),
      .mt_ready  (mt_ready),
      .mt_valid  (mt_valid),
      .mt_index  (mt_index),
      .mt_last   (mt_last),
      .xfer_last (emit_last)
   );

endmodule
